// File: rtl/uart_rx_sipo.sv
// UART receive deserializer: 11-bit frame (start, 8 data LSB first, parity, stop),
// oversampled by OVERSAMPLE, byte delivered with a one-cycle valid pulse and error flags.
module uart_rx_sipo #(
   parameter int   OVERSAMPLE = 16,
   parameter logic PARITY_ODD = 1'b0
) (
   input  logic       baud_clk,
   input  logic       rst,
   input  logic       data_rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       parity_error,
   output logic       frame_error,
   output logic       active_flag
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   // Even mode flags an odd count of ones over data+parity; odd mode the reverse.
   function automatic logic parity_err(input logic [7:0] d, input logic p);
      return (^{d, p}) ^ PARITY_ODD;
   endfunction

   logic          sync1_q, rx_s_q, rx_prev_q;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_bit_q, par_bit_d;
   logic [7:0]    data_out_q, data_out_d;
   logic          parity_error_q, parity_error_d;
   logic          frame_error_q, frame_error_d;
   logic          data_valid_q, data_valid_d;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q + CW'(1);
      idx_d          = idx_q;
      shift_d        = shift_q;
      par_bit_d      = par_bit_q;
      data_out_d     = data_out_q;
      parity_error_d = parity_error_q;
      frame_error_d  = frame_error_q;
      data_valid_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (rx_prev_q && !rx_s_q) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == CNT_MID) begin
               cnt_d = '0;
               idx_d = 3'd0;
               state_d = rx_s_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_s_q;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = S_PARITY;
            end
         end
         S_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               par_bit_d = rx_s_q;
               state_d   = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d          = '0;
               state_d        = S_IDLE;
               data_out_d     = shift_q;
               parity_error_d = parity_err(shift_q, par_bit_q);
               frame_error_d  = !rx_s_q;
               data_valid_d   = 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Synchronizer resets high so the line looks idle coming out of reset.
   always_ff @(posedge baud_clk) begin
      if (rst) begin
         sync1_q        <= 1'b1;
         rx_s_q         <= 1'b1;
         rx_prev_q      <= 1'b1;
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         idx_q          <= 3'd0;
         data_out_q     <= 8'h00;
         parity_error_q <= 1'b0;
         frame_error_q  <= 1'b0;
         data_valid_q   <= 1'b0;
      end else begin
         sync1_q        <= data_rx;
         rx_s_q         <= sync1_q;
         rx_prev_q      <= rx_s_q;
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         data_out_q     <= data_out_d;
         parity_error_q <= parity_error_d;
         frame_error_q  <= frame_error_d;
         data_valid_q   <= data_valid_d;
      end
   end

   always_ff @(posedge baud_clk) begin
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
   end

   assign data_out     = data_out_q;
   assign data_valid   = data_valid_q;
   assign parity_error = parity_error_q;
   assign frame_error  = frame_error_q;
   assign active_flag  = (state_q != S_IDLE);

endmodule
